// File: rtl/ifns_23di_serial_decoder.sv
// Bit-serial IFNS codeword decoder: adds one Fibonacci weight per cycle into an accumulator.
// The weights are regenerated from two registers, so no weight table is stored.
module ifns_23di_serial_decoder #(
  parameter int unsigned CW_W = 33,
  parameter int unsigned V_W  = 23
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cw_valid_i,
  output logic            cw_ready_o,
  input  logic [CW_W-1:0] cw_i,
  output logic            v_valid_o,
  input  logic            v_ready_i,
  output logic [V_W-1:0]  v_o,
  output logic            v_ovf_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [5:0] LastCnt = 6'(CW_W);

  state_e          state_q, state_d;
  logic [CW_W-1:0] sr_q, sr_d;
  logic [V_W-1:0]  fa_q, fa_d;
  logic [V_W-1:0]  fb_q, fb_d;
  logic [V_W:0]    acc_q, acc_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [V_W-1:0]  v_q, v_d;
  logic            ovf_q, ovf_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      sr_q    <= '0;
      fa_q    <= V_W'(1);
      fb_q    <= V_W'(1);
      acc_q   <= '0;
      cnt_q   <= '0;
      v_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    v_d     = v_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (cw_valid_i) begin
          sr_d    = cw_i;
          acc_d   = '0;
          fa_d    = V_W'(1);
          fb_d    = V_W'(1);
          cnt_d   = 6'd1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (cnt_q == LastCnt) begin
          // Top digit skips F(33) and takes F(34), which fb holds at this step.
          if (sr_q[0]) acc_d = acc_q + {1'b0, fb_q};
          v_d     = acc_d[V_W-1:0];
          ovf_d   = acc_d[V_W];
          state_d = StDone;
        end else begin
          if (sr_q[0]) acc_d = acc_q + {1'b0, fa_q};
          fa_d  = fb_q;
          fb_d  = fa_q + fb_q;
          sr_d  = sr_q >> 1;
          cnt_d = cnt_q + 6'd1;
        end
      end
      StDone: begin
        if (v_ready_i) begin
          v_d     = '0;
          ovf_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign cw_ready_o = (state_q == StIdle) && !rst_i;
  assign v_valid_o  = (state_q == StDone);
  assign v_o        = v_q;
  assign v_ovf_o    = ovf_q;
  assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_ifns_23di_serial_decoder.sv
// Randomised self-checking bench for the serial IFNS decoder against a Fibonacci-sum model.
module tb_ifns_23di_serial_decoder;

  logic        clk;
  logic        rst;
  logic        cw_valid;
  logic        cw_ready;
  logic [32:0] cw;
  logic        v_valid;
  logic        v_ready;
  logic [22:0] v;
  logic        v_ovf;
  logic        busy;

  int checks = 0;
  int passes = 0;

  ifns_23di_serial_decoder #(.CW_W(33), .V_W(23)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .cw_valid_i(cw_valid),
    .cw_ready_o(cw_ready),
    .cw_i      (cw),
    .v_valid_o (v_valid),
    .v_ready_i (v_ready),
    .v_o       (v),
    .v_ovf_o   (v_ovf),
    .busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weighted sum from the numeral-system rule: d1..d32 weigh F(1)..F(32), d33 weighs F(34).
  function automatic longint ref_sum(input logic [32:0] c);
    longint f [0:34];
    longint s;
    f[0] = 0;
    f[1] = 1;
    for (int i = 2; i <= 34; i++) f[i] = f[i-1] + f[i-2];
    s = 0;
    for (int i = 1; i <= 32; i++) if (c[i-1]) s += f[i];
    if (c[32]) s += f[34];
    return s;
  endfunction

  function automatic logic [32:0] rand_cw();
    logic [32:0] c;
    c = {1'($urandom_range(1, 0)), 32'($urandom())};
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one codeword, waits (bounded) for v_valid, returns the result and handshakes it.
  task automatic run_cw(input logic [32:0] c, output logic [22:0] vo, output logic ovf,
                        output int lat, output bit timed_out);
    cw       = c;
    cw_valid = 1'b1;
    step();
    cw_valid = 1'b0;
    cw       = rand_cw();
    lat      = 0;
    while (!v_valid && lat < 100) begin
      step();
      lat++;
    end
    timed_out = !v_valid;
    vo        = v;
    ovf       = v_ovf;
    v_ready   = 1'b1;
    step();
    v_ready   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (cw_ready !== 1'b0) $display("FAIL reset_cw_ready: got %b want 0", cw_ready);
    else passes++;
    checks++;
    if ({v_valid, v, v_ovf, busy} !== 26'd0)
      $display("FAIL reset_outputs: got valid=%b v=%0d ovf=%b busy=%b want all 0",
               v_valid, v, v_ovf, busy);
    else passes++;
    rst = 1'b0;
    #1;
    checks++;
    if (cw_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", cw_ready);
    else passes++;
  endtask

  task automatic test_zero();
    int bad_ready;
    int lat;
    cw       = 33'd0;
    cw_valid = 1'b1;
    step();
    cw_valid  = 1'b0;
    bad_ready = 0;
    lat       = 0;
    while (!v_valid && lat < 100) begin
      if (cw_ready !== 1'b0 || busy !== 1'b1) bad_ready++;
      step();
      lat++;
    end
    if (cw_ready !== 1'b0 || busy !== 1'b1) bad_ready++;
    checks++;
    if (lat !== 33) $display("FAIL zero_latency: got %0d want 33", lat);
    else passes++;
    checks++;
    if (bad_ready !== 0) $display("FAIL zero_ready_low: got %0d bad cycles want 0", bad_ready);
    else passes++;
    checks++;
    if (v !== 23'd0 || v_ovf !== 1'b0)
      $display("FAIL zero_value: got v=%0d ovf=%b want v=0 ovf=0", v, v_ovf);
    else passes++;
    v_ready = 1'b1;
    step();
    v_ready = 1'b0;
  endtask

  task automatic test_single_bits();
    logic [32:0] cws  [4];
    int unsigned exps [4];
    logic [22:0] vo;
    logic        ovf;
    int          lat;
    bit          to;
    cws[0] = 33'h000000001; exps[0] = 1;
    cws[1] = 33'h000000004; exps[1] = 2;
    cws[2] = 33'h080000000; exps[2] = 2178309;
    cws[3] = 33'h100000000; exps[3] = 5702887;
    for (int i = 0; i < 4; i++) begin
      run_cw(cws[i], vo, ovf, lat, to);
      checks++;
      if (to || vo !== 23'(exps[i]) || ovf !== 1'b0)
        $display("FAIL single_bit_%0d: got v=%0d ovf=%b timeout=%b want v=%0d ovf=0",
                 i, vo, ovf, to, exps[i]);
      else passes++;
    end
  endtask

  task automatic test_mixed_and_all_ones();
    logic [22:0] vo;
    logic        ovf;
    int          lat;
    bit          to;
    run_cw(33'h000000212, vo, ovf, lat, to);
    checks++;
    if (to || vo !== 23'd61 || ovf !== 1'b0)
      $display("FAIL mixed: got v=%0d ovf=%b want v=61 ovf=0", vo, ovf);
    else passes++;
    run_cw(33'h1FFFFFFFF, vo, ovf, lat, to);
    checks++;
    if (to || vo !== 23'd3017165 || ovf !== 1'b1)
      $display("FAIL all_ones: got v=%0d ovf=%b want v=3017165 ovf=1", vo, ovf);
    else passes++;
  endtask

  task automatic test_random();
    logic [32:0] c;
    logic [22:0] vo;
    logic        ovf;
    int          lat;
    bit          to;
    longint      s;
    for (int i = 0; i < 24; i++) begin
      c = rand_cw();
      if (i % 3 == 0) c = c & rand_cw() & rand_cw();
      s = ref_sum(c);
      run_cw(c, vo, ovf, lat, to);
      checks++;
      if (to || lat !== 33 || vo !== 23'(s) || ovf !== (s >= 64'd8388608))
        $display("FAIL random_%0d: cw=%h got v=%0d ovf=%b lat=%0d want v=%0d ovf=%b lat=33",
                 i, c, vo, ovf, lat, 23'(s), (s >= 64'd8388608));
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] list [3];
    int          acc_cyc [$];
    logic [22:0] got_v [$];
    int          cyc;
    int          idx;
    bit          acc_now;
    bit          hs_now;
    logic [22:0] hs_v;
    list[0] = 33'h000000212;
    list[1] = rand_cw();
    list[2] = rand_cw();
    idx      = 0;
    cyc      = 0;
    cw       = list[0];
    cw_valid = 1'b1;
    v_ready  = 1'b1;
    while (got_v.size() < 3 && cyc < 300) begin
      acc_now = cw_valid && cw_ready;
      hs_now  = v_valid && v_ready;
      hs_v    = v;
      step();
      cyc++;
      if (hs_now) got_v.push_back(hs_v);
      if (acc_now) begin
        acc_cyc.push_back(cyc);
        idx++;
        if (idx < 3) cw = list[idx];
        else cw_valid = 1'b0;
      end
    end
    cw_valid = 1'b0;
    v_ready  = 1'b0;
    checks++;
    if (acc_cyc.size() !== 3 || got_v.size() !== 3)
      $display("FAIL b2b_count: got %0d accepts %0d outputs want 3 and 3",
               acc_cyc.size(), got_v.size());
    else begin
      passes++;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_v[i] !== 23'(ref_sum(list[i])))
          $display("FAIL b2b_value_%0d: got %0d want %0d", i, got_v[i], 23'(ref_sum(list[i])));
        else passes++;
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] !== 35)
          $display("FAIL b2b_spacing_%0d: got %0d want 35", i, acc_cyc[i] - acc_cyc[i-1]);
        else passes++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [32:0] c;
    longint      s;
    int          lat;
    int          bad;
    logic [22:0] v0;
    logic        o0;
    c = rand_cw();
    s = ref_sum(c);
    cw       = c;
    cw_valid = 1'b1;
    step();
    cw_valid = 1'b0;
    lat      = 0;
    while (!v_valid && lat < 100) begin
      step();
      lat++;
    end
    checks++;
    if (!v_valid || v !== 23'(s) || v_ovf !== (s >= 64'd8388608))
      $display("FAIL bp_value: got valid=%b v=%0d ovf=%b want valid=1 v=%0d ovf=%b",
               v_valid, v, v_ovf, 23'(s), (s >= 64'd8388608));
    else passes++;
    v0  = v;
    o0  = v_ovf;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        cw       = rand_cw();
        cw_valid = 1'b1;
      end else cw_valid = 1'b0;
      step();
      if (v !== v0 || v_ovf !== o0 || v_valid !== 1'b1 || cw_ready !== 1'b0) bad++;
    end
    cw_valid = 1'b0;
    checks++;
    if (bad !== 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
    else passes++;
    v_ready = 1'b1;
    step();
    v_ready = 1'b0;
    checks++;
    if (v_valid !== 1'b0 || cw_ready !== 1'b1 || busy !== 1'b0 || v !== 23'd0)
      $display("FAIL bp_release: got valid=%b ready=%b busy=%b v=%0d want 0 1 0 0",
               v_valid, cw_ready, busy, v);
    else passes++;
  endtask

  task automatic test_reset_mid_run();
    logic [22:0] vo;
    logic        ovf;
    int          lat;
    bit          to;
    cw       = 33'h1FFFFFFFF;
    cw_valid = 1'b1;
    step();
    cw_valid = 1'b0;
    // cnt reaches 15 after 14 more edges.
    for (int i = 0; i < 14; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({v_valid, v, v_ovf, busy} !== 26'd0 || cw_ready !== 1'b1)
      $display("FAIL midrun_reset: got valid=%b v=%0d ovf=%b busy=%b ready=%b want 0 0 0 0 1",
               v_valid, v, v_ovf, busy, cw_ready);
    else passes++;
    run_cw(33'h100000001, vo, ovf, lat, to);
    checks++;
    if (to || lat !== 33 || vo !== 23'd5702888 || ovf !== 1'b0)
      $display("FAIL midrun_after: got v=%0d ovf=%b lat=%0d want v=5702888 ovf=0 lat=33",
               vo, ovf, lat);
    else passes++;
  endtask

  initial begin
    rst      = 1'b1;
    cw_valid = 1'b0;
    cw       = '0;
    v_ready  = 1'b0;
    test_reset();
    test_zero();
    test_single_bits();
    test_mixed_and_all_ones();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
